decoder_acc_requant: RTL and testbench

- Downstream stage of the decoder's signed×unsigned product multipliers (signed 26-bit products).
- Consumes one product per beat and accumulates N_TERMS products per output neuron, seeded with a bias.
- Rounds, shifts and saturates the sum to the activation width, optionally applies ReLU, and hands the result to the next layer over a valid/ready handshake.

---
 rtl/decoder_acc_requant.sv | 112 +++++++++++
 tb/tb_decoder_acc_requant.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_acc_requant.sv
// decoder_acc_requant
//   Accumulates N_TERMS signed products per output neuron, seeded with a bias.
//   The final sum is rounded half up, arithmetically shifted, saturated to
//   OUT_WIDTH and presented on a valid/ready output.
//   Optional build macro: DECODER_ACC_RELU_EN (forces negative results to 0).
module decoder_acc_requant #(
    parameter int DIN_WIDTH  = 26,
    parameter int BIAS_WIDTH = 26,
    parameter int ACC_WIDTH  = 34,
    parameter int N_TERMS    = 4,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic signed [DIN_WIDTH-1:0]  in_data,
    input  logic                         in_last,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         err
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    localparam logic signed [ACC_WIDTH-1:0] ROUND_C = ACC_WIDTH'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            count;
    logic signed [ACC_WIDTH-1:0] acc, acc_base, acc_nxt, rounded, shifted;
    logic signed [OUT_WIDTH-1:0] sat_val, act_val;
    logic                        accept, transfer, last_beat;

    assign last_beat = (count == CNT_W'(N_TERMS - 1));
    assign accept    = in_vld && in_rdy;
    assign transfer  = out_vld && out_rdy;

    // State register.
    always_ff @(posedge ap_clk) begin
        // NOTE: every register in this block uses <= so all flops update from pre-edge values.
        if (ap_rst) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // Next-state and input-ready decode.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_nxt = state;
        in_rdy    = 1'b0;
        case (state)
            ST_ACC: begin
                in_rdy = 1'b1;
                if (in_vld && last_beat) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_vld && out_rdy) state_nxt = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // Updated sum and its requantised activation, evaluated every beat.
    always_comb begin
        acc_base = (count == '0) ? ACC_WIDTH'(bias) : acc;
        acc_nxt  = acc_base + ACC_WIDTH'(in_data);
        rounded  = acc_nxt + ROUND_C;
        shifted  = rounded >>> FRAC_SHIFT;
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
        else                        sat_val = shifted[OUT_WIDTH-1:0];
`ifdef DECODER_ACC_RELU_EN
        act_val = sat_val[OUT_WIDTH-1] ? '0 : sat_val;
`else
        act_val = sat_val;
`endif
    end

    // Accumulator, beat counter, result register and sticky framing error.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc      <= '0;
            count    <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                acc <= acc_nxt;
                if (in_last != last_beat) err <= 1'b1;
                if (last_beat) begin
                    count    <= '0;
                    out_data <= act_val;
                    out_vld  <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            // Accept and transfer are exclusive: in_rdy is low while a result waits.
            if (transfer) out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_acc_requant.sv
// Directed testbench for decoder_acc_requant with default parameters.
module tb_decoder_acc_requant;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic               in_vld = 1'b0;
    logic               in_rdy;
    logic signed [25:0] in_data = '0;
    logic               in_last = 1'b0;
    logic signed [25:0] bias = '0;
    logic               out_vld;
    logic               out_rdy = 1'b1;
    logic signed [15:0] out_data;
    logic               err;

    int checks = 0;
    int errors = 0;

    decoder_acc_requant dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .in_last (in_last),
        .bias    (bias),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_data(out_data),
        .err     (err)
    );

    always #5 ap_clk = ~ap_clk;

    // Present one beat for exactly one rising edge; sample 1 time unit later.
    task automatic drive_beat(input logic signed [25:0] d, input logic last);
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        @(posedge ap_clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    // Four beats with correct framing, then check the result and its transfer.
    task automatic run_neuron(input string name,
                              input logic signed [25:0] b,
                              input logic signed [25:0] d0, input logic signed [25:0] d1,
                              input logic signed [25:0] d2, input logic signed [25:0] d3,
                              input logic signed [15:0] exp_val);
        bias = b;
        drive_beat(d0, 1'b0);
        drive_beat(d1, 1'b0);
        drive_beat(d2, 1'b0);
        drive_beat(d3, 1'b1);
        bias = '0;
        checks++;
        if (out_vld !== 1'b1 || out_data !== exp_val || in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: vld=%b data=%0d rdy=%b, expected vld=1 data=%0d rdy=0",
                     name, out_vld, out_data, in_rdy, exp_val);
        end
        @(posedge ap_clk);
        #1;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s transfer: vld=%b rdy=%b, expected vld=0 rdy=1",
                     name, out_vld, in_rdy);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || out_data !== 16'sd0 || err !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: vld=%b data=%0d err=%b rdy=%b, expected 0 0 0 1",
                     out_vld, out_data, err, in_rdy);
        end
    endtask

    task automatic test_basic();
        run_neuron("basic", 26'sd0, 26'sd256, 26'sd512, 26'sd768, 26'sd1024, 16'sd10);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: err=%b, expected 0", err);
        end
    endtask

    task automatic test_rounding();
        run_neuron("round_half_up", 26'sd0,    26'sd128, 26'sd0, 26'sd0, 26'sd0, 16'sd1);
        run_neuron("round_below",   26'sd0,    26'sd127, 26'sd0, 26'sd0, 26'sd0, 16'sd0);
        run_neuron("round_bias",    -26'sd128, 26'sd256, 26'sd0, 26'sd0, 26'sd0, 16'sd1);
    endtask

    task automatic test_negative();
`ifdef DECODER_ACC_RELU_EN
        run_neuron("negative", 26'sd0, -26'sd1000, -26'sd1000, -26'sd1000, -26'sd1000, 16'sd0);
`else
        run_neuron("negative", 26'sd0, -26'sd1000, -26'sd1000, -26'sd1000, -26'sd1000, -16'sd16);
`endif
    endtask

    task automatic test_saturation();
        run_neuron("sat_pos", 26'sd0, 26'sd33554431, 26'sd33554431,
                   26'sd33554431, 26'sd33554431, 16'sd32767);
`ifdef DECODER_ACC_RELU_EN
        run_neuron("sat_neg", 26'sd0, -26'sd33554432, -26'sd33554432,
                   -26'sd33554432, -26'sd33554432, 16'sd0);
`else
        run_neuron("sat_neg", 26'sd0, -26'sd33554432, -26'sd33554432,
                   -26'sd33554432, -26'sd33554432, -16'sd32768);
`endif
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        drive_beat(26'sd512, 1'b0);
        drive_beat(26'sd512, 1'b0);
        drive_beat(26'sd512, 1'b0);
        drive_beat(26'sd512, 1'b1);
        // 4*512 + 128 = 2176 -> 8
        in_vld  = 1'b1;
        in_data = 26'sd9999;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_vld !== 1'b1 || out_data !== 16'sd8 || in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: vld=%b data=%0d rdy=%b, expected vld=1 data=8 rdy=0",
                         i, out_vld, out_data, in_rdy);
            end
            @(posedge ap_clk);
            #1;
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        checks++;
        if (out_vld !== 1'b1 || out_data !== 16'sd8) begin
            errors++;
            $display("FAIL stall_hold: vld=%b data=%0d, expected vld=1 data=8", out_vld, out_data);
        end
        @(posedge ap_clk);
        #1;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b, expected vld=0 rdy=1", out_vld, in_rdy);
        end
        // Stalled beats must not have advanced the count or the sum.
        run_neuron("after_stall", 26'sd0, 26'sd256, 26'sd256, 26'sd256, 26'sd256, 16'sd4);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL after_stall_err: err=%b, expected 0", err);
        end
    endtask

    task automatic test_reset_mid();
        drive_beat(26'sd1000, 1'b0);
        drive_beat(26'sd1000, 1'b0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || err !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: vld=%b err=%b rdy=%b, expected 0 0 1", out_vld, err, in_rdy);
        end
        run_neuron("post_reset", 26'sd0, 26'sd256, 26'sd256, 26'sd256, 26'sd256, 16'sd4);
        // A pending, untransferred result is dropped by reset.
        out_rdy = 1'b0;
        drive_beat(26'sd256, 1'b0);
        drive_beat(26'sd256, 1'b0);
        drive_beat(26'sd256, 1'b0);
        drive_beat(26'sd256, 1'b1);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst  = 1'b0;
        out_rdy = 1'b1;
        checks++;
        if (out_vld !== 1'b0 || out_data !== 16'sd0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pending: vld=%b data=%0d rdy=%b, expected 0 0 1",
                     out_vld, out_data, in_rdy);
        end
    endtask

    task automatic test_framing();
        drive_beat(26'sd0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL framing_clean: err=%b, expected 0", err);
        end
        drive_beat(26'sd0, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL framing_set: err=%b, expected 1", err);
        end
        drive_beat(26'sd0, 1'b0);
        drive_beat(26'sd256, 1'b1);
        // Framing follows count, so the 4th beat still completes the neuron: 256+128 -> 1.
        checks++;
        if (out_vld !== 1'b1 || out_data !== 16'sd1) begin
            errors++;
            $display("FAIL framing_result: vld=%b data=%0d, expected vld=1 data=1", out_vld, out_data);
        end
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL framing_sticky: err=%b, expected 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_negative();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_framing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
